mc_cu: RTL
==========

Name: mc_cu

Overview:
- Multi-cycle control unit, successor to the single-cycle decoder; drives the datapath of the multi-cycle core.
- Sequences each 32-bit MIPS-subset instruction through FETCH/DECODE/EXEC/MEM/WB.
- Uses req/ack handshakes to instruction and data memory, with a parametrised ack timeout.
- Latches the instruction internally and raises a sticky trap on illegal opcodes or memory timeouts.

Parameters:
- MEM_TIMEOUT, 255: max cycles req may stay high without ack before trapping; 0 disables the timeout.
- TMO_W, $clog2(MEM_TIMEOUT+2): width of the wait counter (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- cmd  in  32  instruction word from imem; valid only while imem_ack=1.
- imem_ack  in  1  instruction memory done.
- dmem_ack  in  1  data memory done.
- zero  in  1  ALU zero flag (EXEC of beq).
- imem_req  out  1  instruction fetch request.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write (sw).
- ir_we  out  1  instruction register load strobe.
- pc_we  out  1  PC write enable.
- pc_src  out  2  PC source: 00 PC+4, 01 branch target, 10 jump target.
- alu_op  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT.
- alu_src_b  out  1  0 register rt, 1 sign-extended imm16.
- reg_we  out  1  register file write.
- reg_dst  out  1  1 rd, 0 rt.
- mem_to_reg  out  1  1 write-back from dmem, 0 from ALU.
- trap  out  1  sticky error flag.
- trap_cause  out  2  00 none, 01 illegal, 10 imem timeout, 11 dmem timeout.

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- Reset: rst_n=0 at a rising edge sets state=FETCH, ir=0, wait counter=0, trap_cause=00.
- While rst_n=0, all outputs are forced to 0.
- Outputs are combinational from state, ir and the current inputs. Any output not named for a state is 0 in that state.
- FETCH:
  - imem_req=1.
  - On imem_ack: ir<=cmd, ir_we=1, pc_we=1, pc_src=00; next state DECODE.
  - Otherwise stay and increment the wait counter.
- DECODE: decode on ir[31:26] (op) and ir[5:0] (funct).
  - j (op 0x02): pc_we=1, pc_src=10; next state FETCH.
  - Legal ops: 0x00 with funct 0x20/0x22/0x24/0x25/0x2A, 0x23 lw, 0x2B sw, 0x04 beq, 0x08 addi. Next state EXEC.
  - Anything else: next state TRAP, trap_cause=01.
- EXEC:
  - R-type: alu_op from funct (0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT); alu_src_b=0; next state WB.
  - lw/sw/addi: alu_op=ADD, alu_src_b=1. lw/sw go to MEM; addi goes to WB.
  - beq: alu_op=SUB, alu_src_b=0, pc_src=01, pc_we=zero; next state FETCH.
- MEM:
  - dmem_req=1; dmem_we=1 for sw.
  - On dmem_ack: sw goes to FETCH, lw goes to WB.
  - Otherwise stay and increment the wait counter.
- WB:
  - reg_we=1 (one cycle).
  - R-type: reg_dst=1. lw: reg_dst=0, mem_to_reg=1. addi: reg_dst=0.
  - Next state FETCH.
- TRAP: all strobes 0, trap=1. The only exit is reset.
- Cycle counts with zero-wait memory:
  - R-type 4, lw 5, sw 4, addi 4, beq 3, j 2.
  - Each ack wait cycle adds 1.
- Timeout:
  - Wait counter clears on every state transition.
  - If MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT with req still high and no ack, the next state is TRAP. Cause is 10 in FETCH, 11 in MEM.
  - An ack arriving in the same cycle the counter reaches MEM_TIMEOUT wins; there is no trap.
- Strobe/ack rules:
  - imem_req and dmem_req never assert together.
  - An ack with no req pending is ignored.
  - Strobes last exactly one cycle per state entry.
- Reset mid-operation: return to FETCH with no residual strobes. A pending memory transaction is abandoned.

Optional Feature:
- Macro MC_CU_PERF_EN.
- When defined, add two outputs:
  - retired_cnt (out, 32): increments on each transition into FETCH from DECODE/EXEC/MEM/WB.
  - stall_cnt (out, 32): increments on each FETCH/MEM cycle without ack.
- Both counters are reset to 0 by rst_n, wrap at 2^32, and freeze in TRAP.
- When undefined, these ports and counters do not exist; all other behaviour is unchanged.

Test Plan:
- add $3,$1,$2 (cmd=0x00221820), imem_ack=1 in the first FETCH cycle:
  - Required states: FETCH, DECODE, EXEC (alu_op=0, alu_src_b=0), WB (reg_we=1, reg_dst=1).
  - Back in FETCH at cycle 5.
- lw $2,4($1) (0x8C220004), dmem_ack delayed 3 cycles:
  - MEM lasts 4 cycles with dmem_req=1, dmem_we=0.
  - Then WB with reg_we=1, mem_to_reg=1, reg_dst=0.
- beq (0x10220003):
  - zero=1: EXEC gives pc_we=1, pc_src=01, then FETCH.
  - zero=0: pc_we=0; 3 cycles total.
- Illegal cmd 0xFC000000: DECODE goes to TRAP; trap=1, trap_cause=01; all strobes stay 0 for 20 cycles; rst_n=0 recovers to FETCH.
- MEM_TIMEOUT=4, imem_ack held 0: TRAP with trap_cause=10 after 4 wait cycles. An ack on the 4th cycle instead proceeds to DECODE.
- sw (0xAC220008) with rst_n pulled low mid-MEM: dmem_req=0 during reset, state=FETCH afterwards. With MC_CU_PERF_EN, retired_cnt=0.

Source files
------------

// File: rtl/mc_cu.sv
// mc_cu: multi-cycle control unit sequencing MIPS-subset instructions through FETCH/DECODE/EXEC/MEM/WB.
// Define MC_CU_PERF_EN to add the retired_cnt/stall_cnt performance counters.
module mc_cu #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TMO_W       = $clog2(MEM_TIMEOUT + 2)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] cmd,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  input  logic        zero,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic [2:0]  alu_op,
  output logic        alu_src_b,
  output logic        reg_we,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        trap,
  output logic [1:0]  trap_cause
`ifdef MC_CU_PERF_EN
  ,
  output logic [31:0] retired_cnt,
  output logic [31:0] stall_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    K_RTYPE, K_LW, K_SW, K_BEQ, K_ADDI, K_J, K_ILL
  } kind_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_IMEM    = 2'b10;
  localparam logic [1:0] CAUSE_DMEM    = 2'b11;

  // The wait that reaches MEM_TIMEOUT is the one with the counter at MEM_TIMEOUT-1.
  localparam int TMO_LAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

  state_t           state, state_nx;
  logic [31:0]      ir;
  logic [TMO_W-1:0] wait_cnt;
  logic [1:0]       cause, cause_nx;
  kind_t            kind;
  logic [2:0]       rt_alu;
  logic             funct_ok;
  logic             waiting;
  logic             ir_load;
  logic             tmo_hit;
  logic             ir_fields_unused;

  // Register and immediate fields are consumed by the datapath, not by the sequencer.
  assign ir_fields_unused = ^ir[25:6];

  assign tmo_hit = (MEM_TIMEOUT > 0) && (wait_cnt == TMO_W'(TMO_LAST));

  always_comb begin
    rt_alu   = ALU_ADD;
    funct_ok = 1'b1;
    case (ir[5:0])
      FN_ADD:  rt_alu = ALU_ADD;
      FN_SUB:  rt_alu = ALU_SUB;
      FN_AND:  rt_alu = ALU_AND;
      FN_OR:   rt_alu = ALU_OR;
      FN_SLT:  rt_alu = ALU_SLT;
      default: funct_ok = 1'b0;
    endcase

    case (ir[31:26])
      OP_RTYPE: kind = funct_ok ? K_RTYPE : K_ILL;
      OP_J:     kind = K_J;
      OP_BEQ:   kind = K_BEQ;
      OP_ADDI:  kind = K_ADDI;
      OP_LW:    kind = K_LW;
      OP_SW:    kind = K_SW;
      default:  kind = K_ILL;
    endcase
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_nx   = state;
    cause_nx   = cause;
    waiting    = 1'b0;
    ir_load    = 1'b0;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PC_SEQ;
    alu_op     = ALU_ADD;
    alu_src_b  = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    trap       = 1'b0;
    trap_cause = CAUSE_NONE;

    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_load  = 1'b1;
          ir_we    = 1'b1;
          pc_we    = 1'b1;
          pc_src   = PC_SEQ;
          state_nx = S_DECODE;
        end else begin
          waiting = 1'b1;
          if (tmo_hit) begin
            state_nx = S_TRAP;
            cause_nx = CAUSE_IMEM;
          end
        end
      end

      S_DECODE: begin
        case (kind)
          K_J: begin
            pc_we    = 1'b1;
            pc_src   = PC_JUMP;
            state_nx = S_FETCH;
          end
          K_ILL: begin
            state_nx = S_TRAP;
            cause_nx = CAUSE_ILLEGAL;
          end
          default: state_nx = S_EXEC;
        endcase
      end

      S_EXEC: begin
        case (kind)
          K_RTYPE: begin
            alu_op   = rt_alu;
            state_nx = S_WB;
          end
          K_LW, K_SW: begin
            alu_op    = ALU_ADD;
            alu_src_b = 1'b1;
            state_nx  = S_MEM;
          end
          K_ADDI: begin
            alu_op    = ALU_ADD;
            alu_src_b = 1'b1;
            state_nx  = S_WB;
          end
          K_BEQ: begin
            alu_op   = ALU_SUB;
            pc_src   = PC_BRANCH;
            pc_we    = zero;
            state_nx = S_FETCH;
          end
          default: begin
            state_nx = S_TRAP;
            cause_nx = CAUSE_ILLEGAL;
          end
        endcase
      end

      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (kind == K_SW);
        if (dmem_ack) begin
          state_nx = (kind == K_SW) ? S_FETCH : S_WB;
        end else begin
          waiting = 1'b1;
          if (tmo_hit) begin
            state_nx = S_TRAP;
            cause_nx = CAUSE_DMEM;
          end
        end
      end

      S_WB: begin
        reg_we     = 1'b1;
        reg_dst    = (kind == K_RTYPE);
        mem_to_reg = (kind == K_LW);
        state_nx   = S_FETCH;
      end

      S_TRAP: begin
        trap       = 1'b1;
        trap_cause = cause;
      end

      default: state_nx = S_FETCH;
    endcase

    // Reset overrides everything so no strobe leaks out during or straight after reset.
    if (!rst_n) begin
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_src     = PC_SEQ;
      alu_op     = ALU_ADD;
      alu_src_b  = 1'b0;
      reg_we     = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      trap       = 1'b0;
      trap_cause = CAUSE_NONE;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state    <= S_FETCH;
      ir       <= '0;
      wait_cnt <= '0;
      cause    <= CAUSE_NONE;
    end else begin
      state <= state_nx;
      cause <= cause_nx;
      if (ir_load) ir <= cmd;
      if (state_nx != state) begin
        wait_cnt <= '0;
      end else if (waiting && (wait_cnt != '1)) begin
        wait_cnt <= wait_cnt + TMO_W'(1);
      end
    end
  end

`ifdef MC_CU_PERF_EN
  logic [31:0] retired_q, stall_q;
  logic        retire;

  assign retire = (state_nx == S_FETCH) &&
                  (state inside {S_DECODE, S_EXEC, S_MEM, S_WB});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else if (state != S_TRAP) begin
      if (retire)  retired_q <= retired_q + 32'd1;
      if (waiting) stall_q   <= stall_q + 32'd1;
    end
  end

  assign retired_cnt = rst_n ? retired_q : '0;
  assign stall_cnt   = rst_n ? stall_q   : '0;
`endif

endmodule
